// File: rtl/pipe_out_pkg.sv
// Shared constants for the pipe-out FIFO: default word width, depth and pointer sizing.
package pipe_out_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  // Pointer width for a given depth; a depth of 1 would otherwise yield a zero-width pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_out_ram.sv
// Storage array for the pipe-out FIFO: one synchronous write port, one asynchronous read port.
module pipe_out_ram
  import pipe_out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_out_fifo.sv
// First-word-fall-through FIFO feeding a host pipe-out endpoint, with sticky underflow
// and a running count of words delivered.
module pipe_out_fifo
  import pipe_out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   ti_clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ep_read,
  output logic [WIDTH-1:0]       ep_datain,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   underflow,
  input  logic                   clr_err,
  output logic [15:0]            words_sent
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] head;
  logic             wr_en;
  logic             rd_ok;
  logic             rd_under;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full;
  // Writes in the reset cycle are dropped so the RAM never sees a stale commit.
  assign wr_en     = in_valid && in_ready && !reset;
  assign rd_ok     = ep_read && !empty;
  assign rd_under  = ep_read && empty;
  assign ep_datain = empty ? '0 : head;

  pipe_out_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (ti_clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      underflow  <= 1'b0;
      words_sent <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + 1'b1;
        words_sent <= words_sent + 16'd1;
      end
      case ({wr_en, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A same-cycle underflow wins over the clear request.
      if (rd_under)     underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Bench for pipe_out_fifo: table vectors, directed corner sequences and randomized traffic
// against a queue-based model.
module tb_pipe_out_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic              ti_clk = 1'b0;
  logic              reset = 1'b1;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              ep_read = 1'b0;
  logic [WIDTH-1:0]  ep_datain;
  logic [4:0]        count;
  logic              empty;
  logic              full;
  logic              underflow;
  logic              clr_err = 1'b0;
  logic [15:0]       words_sent;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  bit          muf;
  logic [15:0] msent;

  pipe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ti_clk     (ti_clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ep_read    (ep_read),
    .ep_datain  (ep_datain),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .underflow  (underflow),
    .clr_err    (clr_err),
    .words_sent (words_sent)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] exp_dout;
    exp_dout = (mq.size() > 0) ? mq[0] : 16'h0000;
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("m_ep_datain", 32'(ep_datain), 32'(exp_dout));
    chk("m_underflow", 32'(underflow), 32'(muf));
    chk("m_words_sent", 32'(words_sent), 32'(msent));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare on the falling edge.
  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit rd, input bit cl);
    bit was_empty;
    bit was_full;
    reset = r; in_valid = v; in_data = d; ep_read = rd; clr_err = cl;
    @(posedge ti_clk);
    if (r) begin
      mq.delete();
      muf = 1'b0;
      msent = 16'h0000;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      if (rd && !was_empty) begin
        void'(mq.pop_front());
        msent = msent + 16'd1;
      end
      if (v && !was_full) mq.push_back(d);
      if (rd && was_empty) muf = 1'b1;
      else if (cl) muf = 1'b0;
    end
    @(negedge ti_clk);
    reset = 1'b0; in_valid = 1'b0; ep_read = 1'b0; clr_err = 1'b0;
    check_model();
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [15:0] d;
    bit          rd;
    bit          cl;
    logic [4:0]  e_count;
    logic [15:0] e_dout;
    bit          e_uf;
    logic [15:0] e_sent;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1, 0, 16'h0000, 0, 0, 5'd0, 16'h0000, 0, 16'd0};
    vt[1]  = '{0, 1, 16'hA001, 0, 0, 5'd1, 16'hA001, 0, 16'd0};
    vt[2]  = '{0, 1, 16'hA002, 0, 0, 5'd2, 16'hA001, 0, 16'd0};
    vt[3]  = '{0, 1, 16'hA003, 0, 0, 5'd3, 16'hA001, 0, 16'd0};
    vt[4]  = '{0, 0, 16'h0000, 1, 0, 5'd2, 16'hA002, 0, 16'd1};
    vt[5]  = '{0, 0, 16'h0000, 1, 0, 5'd1, 16'hA003, 0, 16'd2};
    vt[6]  = '{0, 0, 16'h0000, 1, 0, 5'd0, 16'h0000, 0, 16'd3};
    vt[7]  = '{0, 0, 16'h0000, 1, 0, 5'd0, 16'h0000, 1, 16'd3};
    vt[8]  = '{0, 0, 16'h0000, 0, 1, 5'd0, 16'h0000, 0, 16'd3};
    vt[9]  = '{0, 0, 16'h0000, 1, 1, 5'd0, 16'h0000, 1, 16'd3};
    vt[10] = '{0, 0, 16'h0000, 0, 1, 5'd0, 16'h0000, 0, 16'd3};
    vt[11] = '{0, 1, 16'hB001, 1, 0, 5'd1, 16'hB001, 1, 16'd3};
    vt[12] = '{0, 0, 16'h0000, 1, 1, 5'd0, 16'h0000, 0, 16'd4};

    @(negedge ti_clk);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].v, vt[i].d, vt[i].rd, vt[i].cl);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("tbl%0d_dout", i), 32'(ep_datain), 32'(vt[i].e_dout));
      chk($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(vt[i].e_uf));
      chk($sformatf("tbl%0d_sent", i), 32'(words_sent), 32'(vt[i].e_sent));
    end
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Fill to full, then try to overrun with and without a concurrent read.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'hC000 + 16'(i), 0, 0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(0, 1, 16'hDEAD, 0, 0);
    chk("full_drop_count", 32'(count), 32'd16);
    chk("full_drop_head", 32'(ep_datain), 32'h0000C000);
    step(0, 1, 16'hDEAD, 1, 0);
    chk("full_rd_nowrite", 32'(count), 32'd15);
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), 32'(ep_datain), 32'(16'hC000 + 16'(i)));
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Steady state at count 8 with concurrent write and read.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'hD000 + 16'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'hE000 + 16'(i), 1, 0);
      chk($sformatf("steady_count_%0d", i), 32'(count), 32'd8);
    end
    chk("steady_head", 32'(ep_datain), 32'h0000E002);

    // Reset mid-stream with a read pending.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'h5000 + 16'(i), 0, 0);
    chk("pre_rst_count", 32'(count), 32'd5);
    step(1, 1, 16'h7777, 1, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout", 32'(ep_datain), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_sent", 32'(words_sent), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, 16'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    end

    // words_sent wrap: 65535 successful reads, then one more.
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 1, 16'(i), 1, 0);
    chk("sent_ffff", 32'(words_sent), 32'h0000FFFF);
    step(0, 0, 0, 1, 0);
    chk("sent_wrap", 32'(words_sent), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_out_fifo.md
PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width, matching the host-interface pipe width.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO depth in words; power of two, minimum 4.
REQ-003 SHALL have port ti_clk, input, 1: single clock (host-interface clock); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH: fabric word to enqueue.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: FIFO can accept a word this cycle.
REQ-008 SHALL have port ep_read, input, 1: pipe-out read strobe; one word consumed per asserted cycle.
REQ-009 SHALL have port ep_datain, output, WIDTH: word presented to the pipe-out endpoint.
REQ-010 SHALL have port count, output, log2(DEPTH)+1: words currently stored.
REQ-011 SHALL have port empty, output, 1: count == 0.
REQ-012 SHALL have port full, output, 1: count == DEPTH.
REQ-013 SHALL have port underflow, output, 1: sticky flag; a read occurred while empty.
REQ-014 SHALL have port clr_err, input, 1: one-cycle pulse that clears underflow.
REQ-015 SHALL have port words_sent, output, 16: count of successful reads, wraps modulo 2^16.

Function
REQ-016 SHALL drive in_ready = !full combinationally; write accepted when in_valid && in_ready.
REQ-017 SHALL be first-word-fall-through: ep_datain shows the oldest stored word whenever not empty.
REQ-018 SHALL make a word accepted in cycle N visible on ep_datain in cycle N+1 when the FIFO was empty.
REQ-019 SHALL, on ep_read && !empty, retire the head word and show the next word (or 0 if now empty) in the following cycle.
REQ-020 SHALL, on ep_read && empty, return ep_datain = 0, leave count unchanged, set underflow, not increment words_sent.
REQ-021 SHALL drive ep_datain = 0 whenever empty.
REQ-022 SHALL, on simultaneous accepted write and successful read, leave count unchanged and preserve order.
REQ-023 SHALL, when full, refuse writes even if ep_read is asserted in the same cycle (no write-through when full).
REQ-024 SHALL, when empty with simultaneous write and ep_read, accept the write and treat the read as underflow.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; pointer width log2(DEPTH), full/empty from count.
REQ-026 SHALL increment words_sent by 1 per successful read, 16'hFFFF -> 16'h0000.
REQ-027 SHALL give clr_err priority below a same-cycle underflow event (flag stays set).

Reset
REQ-028 SHALL, on reset, force count=0, pointers=0, empty=1, full=0, in_ready=1, ep_datain=0, underflow=0, words_sent=0.
REQ-029 SHALL discard stored words on reset mid-stream; reads and writes in the reset cycle are ignored.
REQ-030 SHALL not require storage RAM contents to be cleared.

Structure
REQ-031 SHALL take WIDTH/DEPTH defaults and pointer-width constant from shared package pipe_out_pkg.
REQ-032 SHALL place storage in one sub-module pipe_out_ram (1 write port, 1 asynchronous read port).
REQ-033 SHALL keep count, pointers, flags and words_sent in pipe_out_fifo.

Verification
REQ-034 Reset, write 16'hA001..16'hA003 back-to-back, then 3 reads -> ep_datain A001,A002,A003; count 3->0; words_sent=3; empty=1.
REQ-035 Write 16 words (DEPTH=16) -> full=1, in_ready=0; 17th write 16'hDEAD dropped; 16 reads return only original data.
REQ-036 ep_read while empty -> ep_datain=0, underflow=1, count=0, words_sent unchanged; clr_err pulse -> underflow=0.
REQ-037 Count=8, simultaneous write and read for 10 cycles -> count stays 8, output order matches input order.
REQ-038 words_sent preset by 65535 reads, one more read -> words_sent=0.
REQ-039 Count=5, assert reset one cycle with ep_read=1 -> next cycle count=0, empty=1, ep_datain=0, underflow=0.
